inst_buffer: RTL and testbench
==============================

# inst_buffer

Instruction buffer between the instruction fetch unit and the decode/execution stage. It accepts one 64-bit fetch beat per cycle, split into two 32-bit opcodes, and stores them in order in a circular FIFO. It presents them one per cycle to decode over a valid/ready handshake. It drives `inst_buff_full` back to fetch early enough to absorb the icache responses already in flight.

## Interface

- `DEPTH`, 16: FIFO capacity in 32-bit opcodes. Must be a power of two, ≥ 4.
- `SKID_PAIRS`, 2: number of fetch beats (opcode pairs) that may still arrive after `inst_buff_full` asserts.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode_vld`  in  1  fetch beat valid, single cycle per beat.
- `opcode0`  in  32  first opcode of the beat (lower half of the icache line).
- `opcode1`  in  32  second opcode of the beat.
- `inst_buff_full`  out  1  registered back-pressure to fetch.
- `flush`  in  1  synchronous clear, used on thread activate/halt.
- `dec_vld`  out  1  head opcode valid.
- `dec_opcode`  out  32  head opcode.
- `dec_rdy`  in  1  decode accepts the head when `dec_vld && dec_rdy`.
- `occupancy`  out  $clog2(DEPTH)+1  current entry count.
- `overflow_err`  out  1  sticky: a beat was dropped.

## Operation

- Storage: `DEPTH` × 32 array, write pointer `wr_ptr` and read pointer `rd_ptr` (each $clog2(DEPTH) bits, natural wrap), and `count` ($clog2(DEPTH)+1 bits).
- Push: when `opcode_vld` and free space (`DEPTH - count`) ≥ 2, write `opcode0` at `wr_ptr` and `opcode1` at `wr_ptr+1` (mod DEPTH), then `wr_ptr += 2`.
  - Both opcodes are always pushed, including zero/NOP values.
  - Order to decode is always `opcode0` then `opcode1`.
- Free space is evaluated on the registered `count`. A same-cycle pop does not create room for a push.
- Overflow: if `opcode_vld` and free space < 2, drop the whole beat (never split a pair), leave the pointers unchanged, and set `overflow_err`. `overflow_err` clears only on reset.
- Pop: when `dec_vld && dec_rdy`, `rd_ptr += 1`.
- Count update: `count_next = count + 2*push - pop`. Simultaneous push and pop gives a net +1.
- Output is first-word fall-through: `dec_vld = (count != 0)` and `dec_opcode = mem[rd_ptr]`. Both are held stable while `dec_vld && !dec_rdy`.
- Full threshold: `inst_buff_full` is registered as `count_next >= DEPTH - 2*SKID_PAIRS` (12 for the defaults).
- Flush: on the next edge, `wr_ptr`, `rd_ptr` and `count` go to 0 and `inst_buff_full` goes to 0.
  - Flush dominates: a same-cycle push or pop is discarded.
  - Flush does not clear `overflow_err`.
  - Array contents are don't-care after flush.
- No state machine beyond the pointer/count logic. The block stays idle when no beats arrive.

## Timing

- Reset (asynchronous assert, synchronous release): pointers, `count` and `occupancy` are 0; `dec_vld`, `inst_buff_full` and `overflow_err` are 0; `dec_opcode` outputs `mem[0]`, which is don't-care while `dec_vld` = 0.
- Reset mid-operation discards all contents immediately.
- Push latency: a beat sampled at edge N makes `dec_vld` = 1 with `dec_opcode` = `opcode0` in the cycle after edge N. `opcode1` follows one accepted pop later.
- Pop takes effect at the edge where `dec_vld && dec_rdy`; the next opcode is presented in the following cycle.
- `inst_buff_full` reflects the post-edge count in the same cycle as `occupancy`. There is no combinational path from any input to any output except `dec_opcode`/`dec_vld` from the registered state.
- Throughput: sustained 2 opcodes in, 1 out per cycle. Fetch must therefore duty-cycle on `inst_buff_full`.

## Test plan

- Reset, then a single beat `opcode0`=0x11111111, `opcode1`=0x22222222 with `dec_rdy`=1 → `dec_opcode` shows 0x11111111 in cycle N+1 and 0x22222222 in cycle N+2; `dec_vld` drops in N+3; `occupancy` goes 2, 1, 0.
- `dec_rdy`=0, push 6 beats → `inst_buff_full` asserts after the 6th beat (count 12); 2 more beats are accepted (count 16); a 9th beat is dropped with `overflow_err`=1 and `occupancy` staying 16.
- Full buffer, hold `opcode_vld`=1 and `dec_rdy`=1 for 1 cycle → the pair is dropped (count 16 → 15, no split write) and `overflow_err` is set.
- Pointer wrap: 40 beats with incrementing opcodes and `dec_rdy` toggling 1/0 → the output sequence is exactly the incrementing sequence with no loss, and `overflow_err` stays 0.
- Flush asserted together with `opcode_vld` while count = 7 → next cycle count 0, `dec_vld` 0, `inst_buff_full` 0, and the flushed beat never appears.
- Reset asserted asynchronously mid-stream with count 10 → all outputs go to their reset values immediately without waiting for a clock edge.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction buffer: 64-bit fetch beats in, 32-bit opcodes out.
// Circular FIFO with early back-pressure to cover in-flight icache beats.
module inst_buffer #(
  parameter int DEPTH      = 16,
  parameter int SKID_PAIRS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     opcode_vld,
  input  logic [31:0]              opcode0,
  input  logic [31:0]              opcode1,
  output logic                     inst_buff_full,
  input  logic                     flush,
  output logic                     dec_vld,
  output logic [31:0]              dec_opcode,
  input  logic                     dec_rdy,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_FILL = CW'(DEPTH - 2);
  localparam logic [CW-1:0] FULL_TH  = CW'(DEPTH - 2*SKID_PAIRS);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          drop;
  logic          pop;

  // Room is judged on the registered count only; a same-cycle pop
  // never makes space for a push.
  assign push = opcode_vld && (count <= MAX_FILL);
  assign drop = opcode_vld && !push;
  assign pop  = dec_vld && dec_rdy;

  assign count_next = count
                    + (push ? CW'(2) : CW'(0))
                    - (pop  ? CW'(1) : CW'(0));

  assign dec_vld    = (count != '0);
  assign dec_opcode = mem[rd_ptr];
  assign occupancy  = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      inst_buff_full <= 1'b0;
      overflow_err   <= 1'b0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      inst_buff_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(2);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drop) overflow_err <= 1'b1;
      count          <= count_next;
      inst_buff_full <= (count_next >= FULL_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr]          <= opcode0;
      mem[wr_ptr + AW'(1)] <= opcode1;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer.
// One task per scenario, inline comparisons, single summary line.
module tb_inst_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        opcode_vld;
  logic [31:0] opcode0;
  logic [31:0] opcode1;
  logic        inst_buff_full;
  logic        flush;
  logic        dec_vld;
  logic [31:0] dec_opcode;
  logic        dec_rdy;
  logic [4:0]  occupancy;
  logic        overflow_err;

  int errors = 0;
  int checks = 0;

  inst_buffer #(.DEPTH(16), .SKID_PAIRS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .opcode_vld     (opcode_vld),
    .opcode0        (opcode0),
    .opcode1        (opcode1),
    .inst_buff_full (inst_buff_full),
    .flush          (flush),
    .dec_vld        (dec_vld),
    .dec_opcode     (dec_opcode),
    .dec_rdy        (dec_rdy),
    .occupancy      (occupancy),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    opcode_vld = 1'b0;
    opcode0 = '0;
    opcode1 = '0;
    flush = 1'b0;
    dec_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (occupancy !== 5'd0 || dec_vld !== 1'b0 ||
        inst_buff_full !== 1'b0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: occ=%0d vld=%b full=%b ovf=%b want 0 0 0 0",
               occupancy, dec_vld, inst_buff_full, overflow_err);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_op [2];
    exp_op[0] = 32'h1111_1111;
    exp_op[1] = 32'h2222_2222;
    dec_rdy = 1'b1;
    opcode_vld = 1'b1;
    opcode0 = exp_op[0];
    opcode1 = exp_op[1];
    tick();
    opcode_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dec_vld !== 1'b1 || dec_opcode !== exp_op[i] ||
          occupancy !== 5'(2 - i)) begin
        errors++;
        $display("FAIL single[%0d]: vld=%b op=%h occ=%0d want 1 %h %0d",
                 i, dec_vld, dec_opcode, occupancy, exp_op[i], 2 - i);
      end
      tick();
    end
    checks++;
    if (dec_vld !== 1'b0 || occupancy !== 5'd0) begin
      errors++;
      $display("FAIL single_empty: vld=%b occ=%0d want 0 0",
               dec_vld, occupancy);
    end
    dec_rdy = 1'b0;
  endtask

  task automatic test_fill_overflow();
    dec_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      opcode_vld = 1'b1;
      opcode0 = 32'hA000_0000 + 32'(2*k);
      opcode1 = 32'hA000_0000 + 32'(2*k + 1);
      tick();
      checks++;
      if (occupancy !== 5'(2*k + 2) ||
          inst_buff_full !== (k >= 5) || overflow_err !== 1'b0) begin
        errors++;
        $display("FAIL fill[%0d]: occ=%0d full=%b ovf=%b want %0d %b 0",
                 k, occupancy, inst_buff_full, overflow_err,
                 2*k + 2, (k >= 5));
      end
    end
    opcode0 = 32'hBAD0_0000;
    opcode1 = 32'hBAD0_0001;
    tick();
    opcode_vld = 1'b0;
    checks++;
    if (occupancy !== 5'd16 || overflow_err !== 1'b1 ||
        inst_buff_full !== 1'b1 || dec_opcode !== 32'hA000_0000) begin
      errors++;
      $display("FAIL overflow: occ=%0d ovf=%b full=%b op=%h want 16 1 1 a0000000",
               occupancy, overflow_err, inst_buff_full, dec_opcode);
    end
  endtask

  task automatic test_full_pop_drop();
    opcode_vld = 1'b1;
    opcode0 = 32'hBAD1_0000;
    opcode1 = 32'hBAD1_0001;
    dec_rdy = 1'b1;
    tick();
    opcode_vld = 1'b0;
    checks++;
    if (occupancy !== 5'd15 || overflow_err !== 1'b1 ||
        dec_opcode !== 32'hA000_0001) begin
      errors++;
      $display("FAIL full_pop: occ=%0d ovf=%b op=%h want 15 1 a0000001",
               occupancy, overflow_err, dec_opcode);
    end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (dec_vld !== 1'b1 || dec_opcode !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: vld=%b op=%h want 1 %h",
                 i, dec_vld, dec_opcode, 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    checks++;
    if (dec_vld !== 1'b0 || occupancy !== 5'd0 || inst_buff_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: vld=%b occ=%0d full=%b want 0 0 0",
               dec_vld, occupancy, inst_buff_full);
    end
    dec_rdy = 1'b0;
  endtask

  task automatic test_flush();
    dec_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      opcode_vld = 1'b1;
      opcode0 = 32'hC000_0000 + 32'(2*k);
      opcode1 = 32'hC000_0000 + 32'(2*k + 1);
      tick();
    end
    opcode_vld = 1'b0;
    dec_rdy = 1'b1;
    tick();
    dec_rdy = 1'b0;
    checks++;
    if (occupancy !== 5'd7 || dec_opcode !== 32'hC000_0001) begin
      errors++;
      $display("FAIL flush_pre: occ=%0d op=%h want 7 c0000001",
               occupancy, dec_opcode);
    end
    flush = 1'b1;
    opcode_vld = 1'b1;
    opcode0 = 32'hDEAD_0000;
    opcode1 = 32'hDEAD_0001;
    dec_rdy = 1'b1;
    tick();
    flush = 1'b0;
    opcode_vld = 1'b0;
    dec_rdy = 1'b0;
    checks++;
    if (occupancy !== 5'd0 || dec_vld !== 1'b0 ||
        inst_buff_full !== 1'b0 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL flush: occ=%0d vld=%b full=%b ovf=%b want 0 0 0 1",
               occupancy, dec_vld, inst_buff_full, overflow_err);
    end
    opcode_vld = 1'b1;
    opcode0 = 32'h5555_5555;
    opcode1 = 32'h6666_6666;
    tick();
    opcode_vld = 1'b0;
    checks++;
    if (occupancy !== 5'd2 || dec_opcode !== 32'h5555_5555) begin
      errors++;
      $display("FAIL flush_after: occ=%0d op=%h want 2 55555555",
               occupancy, dec_opcode);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rx = 0;
    int cyc = 0;
    logic rdy_t = 1'b1;
    while (rx < 80 && cyc < 1000) begin
      opcode_vld = (sent < 40) && !inst_buff_full;
      opcode0 = 32'h0000_1000 + 32'(2*sent);
      opcode1 = 32'h0000_1000 + 32'(2*sent + 1);
      dec_rdy = rdy_t;
      if (dec_vld && dec_rdy) begin
        checks++;
        if (dec_opcode !== 32'h0000_1000 + 32'(rx)) begin
          errors++;
          $display("FAIL wrap[%0d]: op=%h want %h",
                   rx, dec_opcode, 32'h0000_1000 + 32'(rx));
        end
        rx++;
      end
      if (opcode_vld) sent++;
      rdy_t = ~rdy_t;
      tick();
      cyc++;
    end
    opcode_vld = 1'b0;
    dec_rdy = 1'b0;
    checks++;
    if (rx != 80 || overflow_err !== 1'b0 || occupancy !== 5'd0) begin
      errors++;
      $display("FAIL wrap_end: rx=%0d ovf=%b occ=%0d want 80 0 0",
               rx, overflow_err, occupancy);
    end
  endtask

  task automatic test_async_reset();
    dec_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      opcode_vld = 1'b1;
      opcode0 = 32'hE000_0000 + 32'(k);
      opcode1 = 32'hE100_0000 + 32'(k);
      tick();
    end
    opcode_vld = 1'b0;
    checks++;
    if (occupancy !== 5'd10 || dec_vld !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: occ=%0d vld=%b want 10 1",
               occupancy, dec_vld);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (occupancy !== 5'd0 || dec_vld !== 1'b0 ||
        inst_buff_full !== 1'b0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: occ=%0d vld=%b full=%b ovf=%b want 0 0 0 0",
               occupancy, dec_vld, inst_buff_full, overflow_err);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (occupancy !== 5'd0 || dec_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_release: occ=%0d vld=%b want 0 0",
               occupancy, dec_vld);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pop_drop();
    test_flush();
    do_reset();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
